memory_banked_ram: RTL

MEMORY_BANKED_RAM -- requirements
Module: memory_banked_ram

---
 rtl/memory_banked_ram.sv | 74 +++++++
 1 files changed

// File: rtl/memory_banked_ram.sv
// memory_banked_ram: byte-lane RAM with self-clearing FSM, pipelined reads and range checking
module memory_banked_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 512,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    busy,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    read,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] pd [RD_LATENCY];
  logic [RD_LATENCY-1:0] pv;
  logic go, wr_ok, rd_ok, oor, err_q;
  assign busy  = state == CLEAR;
  // init_req in IDLE takes priority and swallows that cycle's accesses
  assign go    = !busy && !init_req;
  assign wr_ok = go && write && {1'b0, wr_addr} < DEPTH;
  assign rd_ok = go && read && {1'b0, rd_addr} < DEPTH;
  assign oor   = go && ((write && !wr_ok) || (read && !rd_ok));
  always_comb begin
    state_nx = busy ? (cnt == LAST ? IDLE : CLEAR) : (init_req ? CLEAR : IDLE);
    cnt_nx   = busy && cnt != LAST ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // array and read data stages carry no reset so they can map onto RAM
  always_ff @(posedge clk) begin
    if (busy) mem[cnt] <= '0;
    else if (wr_ok)
      for (int k = 0; k < NB; k++)
        if (wr_be[k]) mem[wr_addr][8*k+:8] <= wr_data[8*k+:8];
    if (rd_ok) pd[0] <= mem[rd_addr];
    for (int i = 1; i < RD_LATENCY; i++) pd[i] <= pd[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv       <= '0;
      err_q    <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pv[0] <= rd_ok;
      for (int i = 1; i < RD_LATENCY; i++) pv[i] <= pv[i-1];
      err_q    <= oor;
      err      <= err_q;
      rd_valid <= pv[RD_LATENCY-1];
      if (pv[RD_LATENCY-1]) rd_data <= pd[RD_LATENCY-1];
    end
endmodule
